// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master port among NUM_REQ local requesters.
// Round-robin arbitration in IDLE, then one SETUP and one or more ACCESS cycles.
// ACCESS ends on pready, or after TIMEOUT cycles without pready (TIMEOUT=0 never
// times out). Each transfer returns exactly one tagged response pulse.
// Ports:
//   pclk, preset          clock, asynchronous active-low reset
//   req_valid/write       per-requester request and direction
//   req_addr/wdata        per-requester 16-bit payload, requester i at [16i+15:16i]
//   req_ready             combinational one-hot accept strobe (IDLE only)
//   rsp_valid/id/rdata/error  registered response, valid is a one-cycle pulse
//   paddr/pwdata/pwrite/psel/penable  registered APB master outputs
//   prdata/pready/perror  APB slave returns
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*16-1:0] req_addr,
    input  logic [NUM_REQ*16-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [15:0]           paddr,
    output logic [15:0]           pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [15:0]           prdata,
    input  logic                  pready,
    input  logic                  perror
);

    localparam int unsigned DW    = 16;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic [DW-1:0]      addr_arr  [NUM_REQ];
    logic [DW-1:0]      wdata_arr [NUM_REQ];
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    // Unpack the flat payload buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*DW +: DW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(last_q) + 32'd1 + k) % NUM_REQ;
            if (!gnt_any && req_valid[IDX_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

    // Accept strobe is forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (preset && (state_q == S_IDLE) && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    paddr_d   = addr_arr[gnt_idx];
                    pwdata_d  = wdata_arr[gnt_idx];
                    pwrite_d  = req_write[gnt_idx];
                    rsp_id_d  = ID_W'(gnt_idx);
                    last_d    = gnt_idx;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_error_d = perror;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    // This is the TIMEOUT-th ACCESS cycle without pready.
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= S_IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter with a transaction-timeline reference model.
module tb_apb_req_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned TO   = 8;
    localparam int unsigned IW   = 2;
    localparam int          NCYC = 3000;

    logic              pclk, preset;
    logic [NR-1:0]     req_valid, req_write, req_ready;
    logic [NR*16-1:0]  req_addr, req_wdata;
    logic              rsp_valid, rsp_error;
    logic [IW-1:0]     rsp_id;
    logic [15:0]       rsp_rdata, paddr, pwdata, prdata;
    logic              pwrite, psel, penable, pready, perror;

    apb_req_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .ID_W(IW)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .perror    (perror)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int          id;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          err;
        int          w;      // pready-low ACCESS cycles before the slave answers
    } txn_t;

    int n_total, n_bad;
    int k;

    // Requester-side shadow of what the bench drives.
    logic [NR-1:0] rv, rw;
    logic [15:0]   ra [NR];
    logic [15:0]   rd [NR];

    // Reference model: timeline of the current transfer plus held output values.
    bit          busy, in_reset, want_rst;
    int          a, acc_len, pend, last_g, late_k;
    txn_t        cur;
    logic [15:0] e_paddr, e_pwdata, e_rdata;
    logic        e_pwrite, e_err;
    int          e_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        busy     = 1'b0;
        pend     = -1;
        last_g   = NR - 1;
        late_k   = -1;
        e_paddr  = '0;
        e_pwdata = '0;
        e_pwrite = 1'b0;
        e_id     = 0;
        e_rdata  = '0;
        e_err    = 1'b0;
        in_reset = 1'b1;
    endtask

    task automatic new_payload(input int i);
        logic [IW-1:0] ix;
        ix     = IW'(i);
        rw[ix] = 1'($urandom);
        ra[ix] = 16'($urandom);
        rd[ix] = 16'($urandom);
    endtask

    task automatic push_reqs();
        logic [IW-1:0] ix;
        req_valid = rv;
        req_write = rw;
        for (int i = 0; i < NR; i++) begin
            ix = IW'(i);
            req_addr[{ix, 4'b0000} +: 16]  = ra[ix];
            req_wdata[{ix, 4'b0000} +: 16] = rd[ix];
        end
    endtask

    task automatic start_txn(input int g);
        logic [IW-1:0] ix;
        int r;
        ix        = IW'(g);
        busy      = 1'b1;
        a         = k;
        cur.id    = g;
        cur.wr    = rw[ix];
        cur.addr  = ra[ix];
        cur.wdata = rd[ix];
        cur.rdata = 16'($urandom);
        cur.err   = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 9));
        if (k >= 300 && k < 400) cur.w = 0;
        else if (r < 4)          cur.w = 0;
        else if (r < 8)          cur.w = int'($urandom_range(1, 5));
        else if (r == 8)         cur.w = TO - 1;
        else                     cur.w = TO;
        acc_len  = (cur.w >= TO) ? TO : cur.w + 1;
        late_k   = (cur.w >= TO) ? a + TO + 2 : -1;
        e_paddr  = cur.addr;
        e_pwdata = cur.wdata;
        e_pwrite = cur.wr;
        e_id     = g;
        last_g   = g;
    endtask

    // Inputs for cycle k, applied just after its rising edge.
    task automatic drive_cycle();
        bit fair, hit;
        logic [IW-1:0] ix;
        fair = (k >= 300 && k < 400);
        if (pend >= 0) start_txn(pend);
        for (int i = 0; i < NR; i++) begin
            ix = IW'(i);
            if (i == pend) begin
                if (fair || $urandom_range(0, 1) == 1) begin
                    new_payload(i);
                    rv[ix] = 1'b1;
                end else begin
                    rv[ix] = 1'b0;
                end
            end else if (rv[ix]) begin
                if (!fair && $urandom_range(0, 15) == 0) rv[ix] = 1'b0;
            end else if (fair || $urandom_range(0, 2) == 0) begin
                new_payload(i);
                rv[ix] = 1'b1;
            end
        end
        pend = -1;
        if (in_reset) begin
            preset   = 1'b1;
            in_reset = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ix = IW'(i);
                if (!rv[ix]) begin
                    new_payload(i);
                    rv[ix] = 1'b1;
                end
            end
        end
        push_reqs();
        hit    = busy && (k == a + 1 + cur.w);
        pready = hit || (k == late_k);
        prdata = busy ? cur.rdata : 16'($urandom);
        perror = hit ? cur.err : 1'($urandom);
    endtask

    // Compare all outputs for cycle k against the model, then predict the next accept.
    task automatic check_cycle();
        logic          x_psel, x_pen, x_rv;
        logic [NR-1:0] er;
        logic [IW-1:0] ix;
        int            g;
        x_psel = 1'b0;
        x_pen  = 1'b0;
        x_rv   = 1'b0;
        er     = '0;
        if (busy) begin
            if (k == a) begin
                x_psel = 1'b1;
            end else if (k <= a + acc_len) begin
                x_psel = 1'b1;
                x_pen  = 1'b1;
            end else begin
                x_rv    = 1'b1;
                e_rdata = (cur.w >= TO || cur.wr) ? 16'h0 : cur.rdata;
                e_err   = (cur.w >= TO) ? 1'b1 : cur.err;
                busy    = 1'b0;
            end
        end
        chk("psel",      32'(psel),      32'(x_psel));
        chk("penable",   32'(penable),   32'(x_pen));
        chk("rsp_valid", 32'(rsp_valid), 32'(x_rv));
        chk("paddr",     32'(paddr),     32'(e_paddr));
        chk("pwdata",    32'(pwdata),    32'(e_pwdata));
        chk("pwrite",    32'(pwrite),    32'(e_pwrite));
        chk("rsp_id",    32'(rsp_id),    e_id);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        chk("rsp_error", 32'(rsp_error), 32'(e_err));
        pend = -1;
        if (!busy && !in_reset) begin
            for (int j = 0; j < NR; j++) begin
                g  = (last_g + 1 + j) % NR;
                ix = IW'(g);
                if (pend < 0 && rv[ix]) pend = g;
            end
        end
        if (pend >= 0) begin
            ix     = IW'(pend);
            er[ix] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        k         = 0;
        want_rst  = 1'b0;
        a         = 0;
        acc_len   = 0;
        cur       = '{default: 0};
        preset    = 1'b1;
        pready    = 1'b0;
        prdata    = '0;
        perror    = 1'b0;
        rv        = '0;
        rw        = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            new_payload(i);
        end
        rv = '1;
        push_reqs();
        #1 preset = 1'b0;
        @(negedge pclk);
        check_cycle();

        for (int c = 0; c < NCYC; c++) begin
            @(posedge pclk);
            k++;
            #1;
            drive_cycle();
            if (k == 1000 || k == 2000) want_rst = 1'b1;
            if (want_rst && busy && k > a && k <= a + acc_len) begin
                #2 preset = 1'b0;
                #1;
                chk("rst_psel",      32'(psel),      32'd0);
                chk("rst_penable",   32'(penable),   32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                model_reset();
                want_rst = 1'b0;
            end
            @(negedge pclk);
            check_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
